pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 3, number of cycles the back end drains before a trap redirect (legal 1..15).
REQ-002 Ports, in this order (name, direction, width, meaning):
- CLK  in  1  sole clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads that source.
- ex_rd  in  5  destination of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX branch/jump resolved taken.
- mem_req  in  1  MEM stage has a data-memory access outstanding.
- mem_ack  in  1  data memory completes the access this cycle.
- trap_req  in  1  CSR unit requests interrupt/exception entry.
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  EN of the PC and stage registers.
- flush_ifid, flush_idex  out  1 each  load a bubble (valid=0) into that register.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 trap vector.
- trap_ack  out  1  one-cycle pulse: trap vector taken.
- ctrl_state  out  2  00 RUN, 01 DRAIN, 10 REDIRECT (debug).

Function
REQ-003 The block SHALL be a 3-state FSM (RUN, DRAIN, REDIRECT) plus a 4-bit drain counter; all outputs are combinational from state, counter and inputs.
REQ-004 freeze = mem_req & ~mem_ack; while freeze=1, all five enables SHALL be 0, flushes 0, pc_sel 00, trap_ack 0, and state/counter SHALL hold, in every state.
REQ-005 Default in RUN (no event): all enables 1, flushes 0, pc_sel 00.
REQ-006 Load-use hazard = ex_memread & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-007 In RUN, not frozen, hazard, no branch, no trap: en_pc=0, en_ifid=0, flush_idex=1, other enables 1; the stall lasts exactly one cycle.
REQ-008 In RUN, not frozen, ex_br_taken=1, no trap: pc_sel=01, flush_ifid=1, flush_idex=1, all enables 1; a simultaneous hazard SHALL be ignored.
REQ-009 In RUN, not frozen, trap_req=1: next state DRAIN, counter loaded with DRAIN_CYCLES-1; this cycle en_pc=0, flush_ifid=1, en_ifid=1, others 1; trap_req overrides branch and hazard.
REQ-010 DRAIN, not frozen: en_pc=0, flush_ifid=1, flush_idex=1, others 1; ex_br_taken and hazard ignored; counter decrements; at counter 0 next state REDIRECT.
REQ-011 REDIRECT, not frozen: pc_sel=10, en_pc=1, trap_ack=1, flush_ifid=1, flush_idex=1; next state RUN.
REQ-012 trap_req SHALL be sampled only in RUN; trap_req in DRAIN/REDIRECT SHALL be ignored (CSR holds it until trap_ack).
REQ-013 trap_ack SHALL be high for exactly one non-frozen cycle per accepted trap.
REQ-014 mem_ack with mem_req=0 SHALL have no effect.

Reset
REQ-015 RST=1 SHALL immediately force state RUN and counter 0, regardless of CLK; mid-DRAIN reset aborts the trap with no trap_ack.
REQ-016 During and after reset with idle inputs: all enables 1, flushes 0, pc_sel 00, trap_ack 0, ctrl_state 00.

Verification
REQ-017 Reset: assert RST between edges mid-DRAIN -> ctrl_state 00 same cycle, trap_ack never asserted.
REQ-018 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle en_pc=0, en_ifid=0, flush_idex=1; ex_rd=0 same case -> no stall.
REQ-019 Branch+hazard same cycle: ex_br_taken=1 with hazard -> pc_sel=01, flush_ifid=flush_idex=1, en_pc=1.
REQ-020 Memory wait: mem_req=1, mem_ack=0 for 4 cycles then ack -> all enables 0 for 4 cycles, all 1 on ack cycle.
REQ-021 Trap, DRAIN_CYCLES=3: trap_req at cycle 0 -> DRAIN cycles 1-3, REDIRECT cycle 4 with pc_sel=10, trap_ack=1, RUN cycle 5; repeat with 2-cycle freeze in DRAIN -> REDIRECT at cycle 6.
REQ-022 Trap+branch same cycle in RUN -> pc_sel=00, enter DRAIN; branch not redirected.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline hazard, freeze and trap-redirect controller
// Ports: CLK/RST (async, active-high); id_rs1/id_rs2 + *_used, ex_rd, ex_memread -> load-use detect;
//   ex_br_taken -> branch redirect; mem_req/mem_ack -> pipeline freeze; trap_req -> drain + trap vector;
//   en_* stage enables, flush_ifid/flush_idex bubbles, pc_sel (00 +4, 01 branch, 10 trap), trap_ack pulse,
//   ctrl_state (00 RUN, 01 DRAIN, 10 REDIRECT).
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_br_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       trap_req,
  output logic       en_pc,
  output logic       en_ifid,
  output logic       en_idex,
  output logic       en_exmem,
  output logic       en_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] pc_sel,
  output logic       trap_ack,
  output logic [1:0] ctrl_state
);
  typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, REDIRECT = 2'b10} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic freeze, hazard;
  assign freeze = mem_req & ~mem_ack;
  assign hazard = ex_memread & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign ctrl_state = state_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    pc_sel     = 2'b00;
    trap_ack   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (freeze) {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
    else
      case (state_q)
        RUN:
          if (trap_req) begin
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
            state_d    = DRAIN;
            cnt_d      = 4'(DRAIN_CYCLES - 1);
          end else if (ex_br_taken) begin
            pc_sel     = 2'b01;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (hazard) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        DRAIN: begin
          en_pc      = 1'b0;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = (cnt_q == 4'd0) ? REDIRECT : DRAIN;
          cnt_d      = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        end
        REDIRECT: begin
          pc_sel     = 2'b10;
          trap_ack   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven + scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_memread, ex_br_taken, mem_req, mem_ack, trap_req;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, trap_ack;
  logic [1:0] pc_sel, ctrl_state;
  logic [11:0] got;
  int errs = 0, checks = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .trap_req(trap_req), .en_pc(en_pc), .en_ifid(en_ifid),
    .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .pc_sel(pc_sel), .trap_ack(trap_ack), .ctrl_state(ctrl_state));

  assign got = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, pc_sel, trap_ack, ctrl_state};

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex, pc_sel, trap_ack, ctrl_state}
  localparam logic [11:0] E_IDLE = 12'b11111_00_00_0_00;
  localparam logic [11:0] E_HAZ  = 12'b00111_01_00_0_00;
  localparam logic [11:0] E_BR   = 12'b11111_11_01_0_00;
  localparam logic [11:0] E_TRAP = 12'b01111_10_00_0_00;
  localparam logic [11:0] E_FRZ0 = 12'b00000_00_00_0_00;
  localparam logic [11:0] E_FRZ1 = 12'b00000_00_00_0_01;
  localparam logic [11:0] E_FRZ2 = 12'b00000_00_00_0_10;
  localparam logic [11:0] E_DRN  = 12'b01111_11_00_0_01;
  localparam logic [11:0] E_RDR  = 12'b11111_11_10_1_10;

  typedef struct {
    string name;
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic mr, br, mq, ma, tr;
    logic [11:0] exp;
  } vec_t;

  logic [11:0] sb_exp[$];
  string sb_name[$];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic mr, logic br, logic mq, logic ma, logic tr,
                              logic [11:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.mq = mq; v.ma = ma; v.tr = tr; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2; ex_rd = v.rd;
    ex_memread = v.mr; ex_br_taken = v.br; mem_req = v.mq; mem_ack = v.ma; trap_req = v.tr;
    sb_exp.push_back(v.exp);
    sb_name.push_back(v.name);
  endtask

  task automatic check();
    logic [11:0] e;
    string n;
    checks++;
    if (sb_exp.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_underflow got=%b", got);
    end else begin
      e = sb_exp.pop_front();
      n = sb_name.pop_front();
      if (got !== e) begin
        errs++;
        $display("FAIL %s got=%b exp=%b", n, got, e);
      end
    end
  endtask

  // one clock cycle: drive after posedge, sample at negedge; state advances on the next posedge
  task automatic apply(input vec_t v);
    @(posedge CLK);
    #1;
    drive(v);
    @(negedge CLK);
    check();
  endtask

  vec_t idle, tbl[13];

  initial begin
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    tbl[0]  = mk("run_idle",          1, 2, 1, 1, 3, 0, 0, 0, 0, 0, E_IDLE);
    tbl[1]  = mk("loaduse_rs2",       1, 5, 0, 1, 5, 1, 0, 0, 0, 0, E_HAZ);
    tbl[2]  = mk("loaduse_rd0",       0, 0, 1, 1, 0, 1, 0, 0, 0, 0, E_IDLE);
    tbl[3]  = mk("loaduse_rs1",       7, 2, 1, 0, 7, 1, 0, 0, 0, 0, E_HAZ);
    tbl[4]  = mk("rs1_match_unused",  7, 2, 0, 1, 7, 1, 0, 0, 0, 0, E_IDLE);
    tbl[5]  = mk("match_no_load",     5, 5, 1, 1, 5, 0, 0, 0, 0, 0, E_IDLE);
    tbl[6]  = mk("branch",            1, 2, 1, 1, 3, 0, 1, 0, 0, 0, E_BR);
    tbl[7]  = mk("branch_hazard",     5, 5, 1, 1, 5, 1, 1, 0, 0, 0, E_BR);
    tbl[8]  = mk("ack_without_req",   1, 2, 1, 1, 3, 0, 0, 0, 1, 0, E_IDLE);
    tbl[9]  = mk("freeze_hazard",     5, 5, 1, 1, 5, 1, 0, 1, 0, 0, E_FRZ0);
    tbl[10] = mk("freeze_branch",     1, 2, 1, 1, 3, 0, 1, 1, 0, 0, E_FRZ0);
    tbl[11] = mk("freeze_trap",       1, 2, 1, 1, 3, 0, 0, 1, 0, 1, E_FRZ0);
    tbl[12] = mk("after_freeze_trap", 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, E_IDLE);

    drive(mk("reset_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    #1 check();
    repeat (2) @(posedge CLK);
    #1 check_idle_in_reset();
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // stall released once the bubble reaches EX
    apply(mk("stall_cycle", 1, 5, 0, 1, 5, 1, 0, 0, 0, 0, E_HAZ));
    apply(mk("stall_released", 1, 5, 0, 1, 6, 0, 0, 0, 0, 0, E_IDLE));

    // memory wait: 4 frozen cycles then ack
    for (int i = 0; i < 4; i++) apply(mk("mem_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ0));
    apply(mk("mem_ack_cycle", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_IDLE));

    // trap with trap_req held until ack; branch/hazard ignored during drain
    apply(mk("trap_c0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_TRAP));
    apply(mk("drain_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    apply(mk("drain_c2_br_haz", 5, 5, 1, 1, 5, 1, 1, 0, 0, 1, E_DRN));
    apply(mk("drain_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    apply(mk("redirect_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RDR));
    apply(mk("run_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

    // trap with 2-cycle freeze inside drain
    apply(mk("ftrap_c0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_TRAP));
    apply(mk("ftrap_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    apply(mk("ftrap_frz_c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_FRZ1));
    apply(mk("ftrap_frz_c3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_FRZ1));
    apply(mk("ftrap_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    apply(mk("ftrap_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    apply(mk("ftrap_redirect_c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RDR));
    apply(mk("ftrap_run_c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

    // trap + branch same cycle: no branch redirect; freeze during REDIRECT holds the ack off
    apply(mk("trapbr_c0", 1, 2, 1, 1, 3, 0, 1, 0, 0, 1, E_TRAP));
    for (int i = 0; i < 3; i++) apply(mk("trapbr_drain", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_DRN));
    apply(mk("trapbr_frz_redirect", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_FRZ2));
    apply(mk("trapbr_redirect", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RDR));
    apply(mk("trapbr_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

    // reset asserted between edges mid-DRAIN aborts the trap
    apply(mk("rst_trap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_TRAP));
    apply(mk("rst_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DRN));
    #2;
    RST = 1'b1;
    drive(mk("rst_mid_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    #1 check();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) apply(mk("post_rst_no_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

    checks++;
    if (sb_exp.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  task automatic check_idle_in_reset();
    drive(idle);
    check();
  endtask
endmodule
